gpio_bus_bridge: RTL and testbench

Time-multiplexes the 8227 core's 16-bit address and 8-bit data bus onto the shared 8-bit GPIO breakout pins, so the core reaches off-chip memory through the chip's limited pin budget. Sits between `top8227` and the GPIO pad wrapper. It sequences address-low, address-high and data phases with strobes. It waits on an external acknowledge, and stalls the core until the access completes or times out.

---
 rtl/bus_bridge_pkg.sv | 15 +
 rtl/sync2.sv | 24 ++
 rtl/gpio_bus_bridge.sv | 186 ++++++++++++++++++
 tb/tb_gpio_bus_bridge.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_bridge_pkg.sv
// Shared types and constants for the GPIO bus bridge.
package bus_bridge_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ALO,
      AHI,
      DATA,
      DONE
   } bridge_state_t;

   localparam logic [7:0] RDATA_TIMEOUT = 8'hFF;
   localparam logic [7:0] RDATA_WRITE   = 8'h00;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous control bit.
module sync2 (
   input  logic clk,
   input  logic nrst,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk) begin
      if (!nrst) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/gpio_bus_bridge.sv
// Multiplexes the core's 16-bit address / 8-bit data bus onto 8 GPIO pins
// as address-low, address-high and data phases, stalling the core until ack or timeout.
module gpio_bus_bridge
   import bus_bridge_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 15,
   parameter int DATA_MIN       = 2
) (
   input  logic        clk,
   input  logic        nrst,
   input  logic        cpu_req,
   input  logic        cpu_rw,
   input  logic [15:0] cpu_addr,
   input  logic [7:0]  cpu_wdata,
   output logic [7:0]  cpu_rdata,
   output logic        cpu_ready,
   output logic        bus_err,
   output logic [7:0]  pad_out,
   output logic        pad_oe,
   input  logic [7:0]  pad_in,
   output logic        pad_ale_lo,
   output logic        pad_ale_hi,
   output logic        pad_rd_n,
   output logic        pad_wr_n,
   input  logic        pad_ack
);

   localparam logic [7:0] MIN_CNT = 8'(DATA_MIN);
   localparam logic [7:0] TO_CNT  = 8'(TIMEOUT_CYCLES);

   bridge_state_t state_q, state_d;
   logic [15:0]   addr_q, addr_d;
   logic          rw_q, rw_d;
   logic [7:0]    wdata_q, wdata_d;
   logic [7:0]    cnt_q, cnt_d;
   logic          timeoutHit;
   logic          ack_s;

   logic [7:0]    padOut_q, padOut_d;
   logic          padOe_q, padOe_d;
   logic          aleLo_q, aleLo_d;
   logic          aleHi_q, aleHi_d;
   logic          rdN_q, rdN_d;
   logic          wrN_q, wrN_d;
   logic          ready_q, ready_d;
   logic          err_q, err_d;
   logic [7:0]    rdata_q, rdata_d;

   sync2 u_ackSync (
      .clk  (clk),
      .nrst (nrst),
      .d_i  (pad_ack),
      .q_o  (ack_s)
   );

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      rw_d       = rw_q;
      wdata_d    = wdata_q;
      cnt_d      = cnt_q;
      timeoutHit = 1'b0;

      case (state_q)
         IDLE: begin
            if (cpu_req) begin
               addr_d  = cpu_addr;
               rw_d    = cpu_rw;
               wdata_d = cpu_wdata;
               state_d = ALO;
            end
         end
         ALO: state_d = AHI;
         AHI: begin
            state_d = DATA;
            cnt_d   = 8'd1;
         end
         DATA: begin
            // Ack is checked first so a coincident ack and timeout counts as success.
            if (ack_s && (cnt_q >= MIN_CNT)) begin
               state_d = DONE;
            end else if (cnt_q >= TO_CNT) begin
               state_d    = DONE;
               timeoutHit = 1'b1;
            end else if (cnt_q != 8'hFF) begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         DONE: begin
            state_d = IDLE;
            cnt_d   = 8'd0;
         end
         default: state_d = IDLE;
      endcase

      // Outputs are decoded from the next state so the registered pins line up with state_q.
      padOut_d = 8'h00;
      padOe_d  = 1'b0;
      aleLo_d  = 1'b0;
      aleHi_d  = 1'b0;
      rdN_d    = 1'b1;
      wrN_d    = 1'b1;
      ready_d  = 1'b0;
      err_d    = 1'b0;
      rdata_d  = 8'h00;

      case (state_d)
         ALO: begin
            padOut_d = addr_d[7:0];
            padOe_d  = 1'b1;
            aleLo_d  = 1'b1;
         end
         AHI: begin
            padOut_d = addr_d[15:8];
            padOe_d  = 1'b1;
            aleHi_d  = 1'b1;
         end
         DATA: begin
            if (rw_d) begin
               rdN_d = 1'b0;
            end else begin
               padOut_d = wdata_d;
               padOe_d  = 1'b1;
               wrN_d    = 1'b0;
            end
         end
         DONE: begin
            ready_d = 1'b1;
            err_d   = timeoutHit;
            if (timeoutHit) begin
               rdata_d = RDATA_TIMEOUT;
            end else if (rw_d) begin
               rdata_d = pad_in;
            end else begin
               rdata_d = RDATA_WRITE;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!nrst) begin
         state_q  <= IDLE;
         addr_q   <= 16'h0000;
         rw_q     <= 1'b0;
         wdata_q  <= 8'h00;
         cnt_q    <= 8'd0;
         padOut_q <= 8'h00;
         padOe_q  <= 1'b0;
         aleLo_q  <= 1'b0;
         aleHi_q  <= 1'b0;
         rdN_q    <= 1'b1;
         wrN_q    <= 1'b1;
         ready_q  <= 1'b0;
         err_q    <= 1'b0;
         rdata_q  <= 8'h00;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         rw_q     <= rw_d;
         wdata_q  <= wdata_d;
         cnt_q    <= cnt_d;
         padOut_q <= padOut_d;
         padOe_q  <= padOe_d;
         aleLo_q  <= aleLo_d;
         aleHi_q  <= aleHi_d;
         rdN_q    <= rdN_d;
         wrN_q    <= wrN_d;
         ready_q  <= ready_d;
         err_q    <= err_d;
         rdata_q  <= rdata_d;
      end
   end

   assign pad_out    = padOut_q;
   assign pad_oe     = padOe_q;
   assign pad_ale_lo = aleLo_q;
   assign pad_ale_hi = aleHi_q;
   assign pad_rd_n   = rdN_q;
   assign pad_wr_n   = wrN_q;
   assign cpu_ready  = ready_q;
   assign bus_err    = err_q;
   assign cpu_rdata  = rdata_q;

endmodule

// File: tb/tb_gpio_bus_bridge.sv
// Directed self-checking bench for gpio_bus_bridge with default parameters.
module tb_gpio_bus_bridge;

   logic        clk = 1'b0;
   logic        nrst = 1'b0;
   logic        cpu_req = 1'b0;
   logic        cpu_rw = 1'b0;
   logic [15:0] cpu_addr = 16'h0000;
   logic [7:0]  cpu_wdata = 8'h00;
   logic [7:0]  pad_in = 8'h00;
   logic        pad_ack = 1'b0;
   logic [7:0]  cpu_rdata;
   logic        cpu_ready;
   logic        bus_err;
   logic [7:0]  pad_out;
   logic        pad_oe;
   logic        pad_ale_lo;
   logic        pad_ale_hi;
   logic        pad_rd_n;
   logic        pad_wr_n;

   int assertCount = 0;
   int failCount = 0;

   gpio_bus_bridge dut (
      .clk        (clk),
      .nrst       (nrst),
      .cpu_req    (cpu_req),
      .cpu_rw     (cpu_rw),
      .cpu_addr   (cpu_addr),
      .cpu_wdata  (cpu_wdata),
      .cpu_rdata  (cpu_rdata),
      .cpu_ready  (cpu_ready),
      .bus_err    (bus_err),
      .pad_out    (pad_out),
      .pad_oe     (pad_oe),
      .pad_in     (pad_in),
      .pad_ale_lo (pad_ale_lo),
      .pad_ale_hi (pad_ale_hi),
      .pad_rd_n   (pad_rd_n),
      .pad_wr_n   (pad_wr_n),
      .pad_ack    (pad_ack)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      assertCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic applyStimulus(input logic rw, input logic [15:0] addr, input logic [7:0] wdata);
      cpu_req   = 1'b1;
      cpu_rw    = rw;
      cpu_addr  = addr;
      cpu_wdata = wdata;
   endtask

   // Runs until cpu_ready, counting strobed DATA cycles and raising pad_ack in DATA cycle ackAt.
   task automatic waitReady(input int ackAt, input logic [7:0] expOut, output int dataCycles,
                            output int badCycles, output logic [7:0] rdataSeen, output logic errSeen);
      bit done = 1'b0;
      dataCycles = 0;
      badCycles  = 0;
      rdataSeen  = 8'h00;
      errSeen    = 1'b0;
      for (int i = 0; i < 60 && !done; i++) begin
         tick();
         if (cpu_ready) begin
            done      = 1'b1;
            rdataSeen = cpu_rdata;
            errSeen   = bus_err;
         end else if (!pad_wr_n) begin
            dataCycles++;
            if (pad_out !== expOut || pad_oe !== 1'b1 || pad_rd_n !== 1'b1) badCycles++;
         end else if (!pad_rd_n) begin
            dataCycles++;
            if (pad_oe !== 1'b0) badCycles++;
         end
         if (!done && ackAt > 0 && dataCycles == ackAt) pad_ack = 1'b1;
      end
      if (!done) checkOutput("readyTimeout", 32'd0, 32'd1);
   endtask

   initial begin
      int n;
      int bad;
      logic [7:0] rd;
      logic er;
      int readyAt;
      int aleAt;
      int readyCount;
      int aleCount;

      // Reset values
      nrst = 1'b0;
      idleCycles(2);
      checkOutput("rstPadOut", 32'(pad_out), 32'h00);
      checkOutput("rstStrobes", 32'({pad_oe, pad_ale_lo, pad_ale_hi, pad_rd_n, pad_wr_n}), 32'b00011);
      checkOutput("rstCpu", 32'({cpu_ready, bus_err, cpu_rdata}), 32'h000);
      nrst = 1'b1;
      idleCycles(2);

      // Write 0x1234 <- 0xAB, ack raised in DATA cycle 1
      pad_ack = 1'b0;
      applyStimulus(1'b0, 16'h1234, 8'hAB);
      tick();
      checkOutput("t1AloOut", 32'(pad_out), 32'h34);
      checkOutput("t1AloStrobe", 32'({pad_ale_lo, pad_ale_hi, pad_oe}), 32'b101);
      cpu_req = 1'b0;
      tick();
      checkOutput("t1AhiOut", 32'(pad_out), 32'h12);
      checkOutput("t1AhiStrobe", 32'({pad_ale_lo, pad_ale_hi, pad_oe}), 32'b011);
      waitReady(1, 8'hAB, n, bad, rd, er);
      checkOutput("t1DataCycles", 32'(n), 32'd3);
      checkOutput("t1DataBad", 32'(bad), 32'd0);
      checkOutput("t1Err", 32'(er), 32'd0);
      checkOutput("t1Rdata", 32'(rd), 32'h00);
      checkOutput("t1DoneStrobe", 32'({pad_wr_n, pad_oe}), 32'b10);
      pad_ack = 1'b0;
      tick();
      checkOutput("t1ReadyPulse", 32'(cpu_ready), 32'd0);
      idleCycles(3);

      // Read 0xFFFC with a stale ack already high
      pad_ack = 1'b1;
      pad_in  = 8'h5A;
      idleCycles(3);
      applyStimulus(1'b1, 16'hFFFC, 8'h00);
      tick();
      checkOutput("t2AloOut", 32'(pad_out), 32'hFC);
      cpu_req = 1'b0;
      tick();
      checkOutput("t2AhiOut", 32'(pad_out), 32'hFF);
      waitReady(0, 8'h00, n, bad, rd, er);
      checkOutput("t2DataCycles", 32'(n), 32'd2);
      checkOutput("t2DataBad", 32'(bad), 32'd0);
      checkOutput("t2Rdata", 32'(rd), 32'h5A);
      checkOutput("t2Err", 32'(er), 32'd0);

      // Read with ack never asserted times out
      pad_ack = 1'b0;
      pad_in  = 8'h3C;
      idleCycles(3);
      applyStimulus(1'b1, 16'h0100, 8'h00);
      tick();
      cpu_req = 1'b0;
      tick();
      waitReady(0, 8'h00, n, bad, rd, er);
      checkOutput("t3DataCycles", 32'(n), 32'd15);
      checkOutput("t3Rdata", 32'(rd), 32'hFF);
      checkOutput("t3Err", 32'(er), 32'd1);
      tick();
      checkOutput("t3ErrPulse", 32'({cpu_ready, bus_err}), 32'b00);

      // Ack reaches the FSM in the last allowed cycle: success wins
      pad_in = 8'hC3;
      idleCycles(2);
      applyStimulus(1'b1, 16'h0200, 8'h00);
      tick();
      cpu_req = 1'b0;
      tick();
      waitReady(13, 8'h00, n, bad, rd, er);
      checkOutput("t4DataCycles", 32'(n), 32'd15);
      checkOutput("t4Err", 32'(er), 32'd0);
      checkOutput("t4Rdata", 32'(rd), 32'hC3);
      pad_ack = 1'b0;
      idleCycles(3);

      // Ack at DATA cycle 3 stretches DATA to 5 cycles
      applyStimulus(1'b0, 16'h0F0F, 8'h99);
      tick();
      cpu_req = 1'b0;
      tick();
      waitReady(3, 8'h99, n, bad, rd, er);
      checkOutput("t5DataCycles", 32'(n), 32'd5);
      checkOutput("t5DataBad", 32'(bad), 32'd0);
      checkOutput("t5Err", 32'(er), 32'd0);
      pad_ack = 1'b0;
      idleCycles(3);

      // Reset during the DATA phase of a write
      applyStimulus(1'b0, 16'h2222, 8'h77);
      tick();
      cpu_req = 1'b0;
      tick();
      tick();
      checkOutput("t6InData", 32'(pad_wr_n), 32'd0);
      nrst = 1'b0;
      tick();
      checkOutput("t6RstStrobe", 32'({pad_wr_n, pad_oe, pad_ale_lo}), 32'b100);
      checkOutput("t6RstPadOut", 32'(pad_out), 32'h00);
      nrst = 1'b1;
      readyCount = 0;
      aleCount   = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (cpu_ready) readyCount++;
         if (pad_ale_lo) aleCount++;
      end
      checkOutput("t6NoReady", 32'(readyCount), 32'd0);
      checkOutput("t6StayIdle", 32'(aleCount), 32'd0);

      // Back-to-back reads with cpu_req held and ack held high
      pad_ack = 1'b1;
      pad_in  = 8'h11;
      idleCycles(3);
      applyStimulus(1'b1, 16'h4000, 8'h00);
      readyAt = -1;
      aleAt   = -1;
      for (int i = 1; i <= 30 && aleAt < 0; i++) begin
         tick();
         if (cpu_ready && readyAt < 0) readyAt = i;
         if (pad_ale_lo && readyAt >= 0) aleAt = i;
      end
      checkOutput("t7ReadyLatency", 32'(readyAt), 32'd5);
      checkOutput("t7IdleGap", 32'(aleAt - readyAt), 32'd2);
      cpu_req = 1'b0;
      waitReady(0, 8'h00, n, bad, rd, er);
      checkOutput("t7SecondCycles", 32'(n), 32'd2);
      checkOutput("t7SecondRdata", 32'(rd), 32'h11);
      idleCycles(2);

      // Address and data changed after the request are ignored
      applyStimulus(1'b0, 16'hBEEF, 8'h55);
      tick();
      checkOutput("t8AloOut", 32'(pad_out), 32'hEF);
      cpu_addr  = 16'h0000;
      cpu_wdata = 8'h00;
      cpu_req   = 1'b0;
      tick();
      checkOutput("t8AhiOut", 32'(pad_out), 32'hBE);
      waitReady(0, 8'h55, n, bad, rd, er);
      checkOutput("t8DataCycles", 32'(n), 32'd2);
      checkOutput("t8DataBad", 32'(bad), 32'd0);
      idleCycles(2);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
